// File: rtl/rcservo_frame_scheduler_pkg.sv
// Shared definitions for the RC-servo frame scheduler: FSM encodings,
// position width and the parameter legality rule.
package rcservo_frame_scheduler_pkg;

  localparam int POS_W = 32;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_UPDATE = 3'd1;
  localparam logic [2:0] ST_PULSE  = 3'd2;
  localparam logic [2:0] ST_GAP    = 3'd3;
  localparam logic [2:0] ST_WAIT   = 3'd4;

  // All slots plus the update phase must fit in one frame, and every
  // possible pulse width must be positive and fit inside its slot.
  function automatic bit params_legal(int ch, int frame_len, int slot_len,
                                      int center, int minmax);
    return (ch >= 1) && (ch + ch * slot_len <= frame_len) &&
           (center + minmax <= slot_len) && (center > minmax);
  endfunction

endpackage

// File: rtl/rcservo_frame_scheduler_pos_integrator.sv
// Combinational velocity-to-position step: scale, slew-clamp, then
// saturating add into the +/- SERVO_MINMAX window.
module rcservo_pos_integrator
  import rcservo_frame_scheduler_pkg::*;
#(
  parameter int VEL_SHIFT    = 8,
  parameter int MAX_SLEW     = 256,
  parameter int SERVO_MINMAX = 24000
) (
  input  logic signed [POS_W-1:0] pos,
  input  logic signed [POS_W-1:0] cmd,
  output logic signed [POS_W-1:0] pos_next
);

  localparam logic signed [POS_W:0] SLEW_HI = (POS_W+1)'(MAX_SLEW);
  localparam logic signed [POS_W:0] SLEW_LO = -SLEW_HI;
  localparam logic signed [POS_W:0] LIM_HI  = (POS_W+1)'(SERVO_MINMAX);
  localparam logic signed [POS_W:0] LIM_LO  = -LIM_HI;

  logic signed [POS_W-1:0] shifted;
  logic signed [POS_W:0]   delta;
  logic signed [POS_W:0]   sum;

  always_comb begin
    shifted = cmd >>> VEL_SHIFT;
    delta   = {shifted[POS_W-1], shifted};
    if (delta > SLEW_HI)
      delta = SLEW_HI;
    else if (delta < SLEW_LO)
      delta = SLEW_LO;
    // One extra bit keeps the sum exact before saturation.
    sum = {pos[POS_W-1], pos} + delta;
    if (sum > LIM_HI)
      sum = LIM_HI;
    else if (sum < LIM_LO)
      sum = LIM_LO;
    pos_next = sum[POS_W-1:0];
  end

endmodule

// File: rtl/rcservo_frame_scheduler.sv
// Frame scheduler for CHANNELS RC servos: one shared integrator updates
// positions round-robin, then each channel pulses in its own slot.
module rcservo_frame_scheduler
  import rcservo_frame_scheduler_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int FRAME_LEN    = 480000,
  parameter int SLOT_LEN     = 110000,
  parameter int SERVO_CENTER = 72000,
  parameter int SERVO_MINMAX = 24000,
  parameter int VEL_SHIFT    = 8,
  parameter int MAX_SLEW     = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [32*CHANNELS-1:0]    jointFreqCmd,
  output logic [32*CHANNELS-1:0]    jointFeedback,
  output logic [CHANNELS-1:0]       PWM,
  output logic                      frame_start,
  output logic                      busy,
  output logic [2:0]                dbg_state
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

  if (!params_legal(CHANNELS, FRAME_LEN, SLOT_LEN, SERVO_CENTER, SERVO_MINMAX)) begin : g_bad_params
    $error("rcservo_frame_scheduler: illegal parameter combination");
  end

  logic [2:0]              state, st_n;
  logic [31:0]             frame_cnt, fc_n;
  logic [31:0]             slot_cnt, sc_n;
  logic [31:0]             width_q, wid_n;
  logic [CH_W-1:0]         ch_idx, ch_n, start_ch;
  logic [CHANNELS-1:0]     pwm_n;
  logic signed [POS_W-1:0] pos [CHANNELS];
  logic signed [POS_W-1:0] int_out, latch_pos;
  logic                    upd, slot_done, start, go_idle, wrap;

  rcservo_pos_integrator #(
    .VEL_SHIFT    (VEL_SHIFT),
    .MAX_SLEW     (MAX_SLEW),
    .SERVO_MINMAX (SERVO_MINMAX)
  ) u_integrator (
    .pos      (pos[ch_idx]),
    .cmd      (jointFreqCmd[32*ch_idx +: 32]),
    .pos_next (int_out)
  );

  // Valid/ready is not used here: commands are level inputs sampled in the
  // owning channel's UPDATE cycle, outputs are plain registered levels.
  always_comb begin
    st_n      = state;
    fc_n      = frame_cnt + 32'd1;
    sc_n      = slot_cnt + 32'd1;
    ch_n      = ch_idx;
    wid_n     = width_q;
    pwm_n     = PWM;
    upd       = 1'b0;
    slot_done = 1'b0;
    start     = 1'b0;
    go_idle   = 1'b0;
    wrap      = 1'b0;
    start_ch  = '0;
    latch_pos = '0;
    case (state)
      ST_IDLE: begin
        fc_n  = '0;
        sc_n  = '0;
        ch_n  = '0;
        pwm_n = '0;
        if (enable) st_n = ST_UPDATE;
      end
      ST_UPDATE: begin
        upd = 1'b1;
        if (ch_idx == LAST_CH) begin
          if (enable) start = 1'b1;
          else        go_idle = 1'b1;
        end else begin
          ch_n = ch_idx + 1'b1;
        end
      end
      ST_PULSE: begin
        // A running pulse ignores enable until its full width has elapsed.
        if (slot_cnt == width_q - 32'd1) begin
          pwm_n = '0;
          if (!enable)                       go_idle = 1'b1;
          else if (slot_cnt == SLOT_LEN - 1) slot_done = 1'b1;
          else                               st_n = ST_GAP;
        end
      end
      ST_GAP: begin
        if (!enable)                       go_idle = 1'b1;
        else if (slot_cnt == SLOT_LEN - 1) slot_done = 1'b1;
      end
      ST_WAIT: begin
        if (frame_cnt == FRAME_LEN - 1) wrap = 1'b1;
        else if (!enable)               go_idle = 1'b1;
      end
      default: go_idle = 1'b1;
    endcase

    if (slot_done) begin
      if (ch_idx != LAST_CH) begin
        start    = 1'b1;
        start_ch = ch_idx + 1'b1;
      end else if (frame_cnt == FRAME_LEN - 1) begin
        wrap = 1'b1;
      end else begin
        st_n = ST_WAIT;
      end
    end

    if (wrap) begin
      fc_n = '0;
      sc_n = '0;
      ch_n = '0;
      st_n = enable ? ST_UPDATE : ST_IDLE;
    end

    if (start) begin
      // Channel updated this very cycle (CHANNELS==1) needs the fresh value.
      latch_pos = (upd && ch_idx == start_ch) ? int_out : pos[start_ch];
      st_n      = ST_PULSE;
      ch_n      = start_ch;
      sc_n      = '0;
      wid_n     = SERVO_CENTER + latch_pos;
      pwm_n     = '0;
      pwm_n[start_ch] = 1'b1;
    end

    if (go_idle) begin
      st_n  = ST_IDLE;
      fc_n  = '0;
      sc_n  = '0;
      ch_n  = '0;
      pwm_n = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      frame_cnt <= '0;
      slot_cnt  <= '0;
      ch_idx    <= '0;
      width_q   <= '0;
      PWM       <= '0;
      for (int k = 0; k < CHANNELS; k++) pos[k] <= '0;
    end else begin
      state     <= st_n;
      frame_cnt <= fc_n;
      slot_cnt  <= sc_n;
      ch_idx    <= ch_n;
      width_q   <= wid_n;
      PWM       <= pwm_n;
      if (upd) pos[ch_idx] <= int_out;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_fb
    assign jointFeedback[32*k +: 32] = pos[k];
  end

  assign busy        = (state != ST_IDLE);
  assign frame_start = busy && (frame_cnt == 32'd0);
  assign dbg_state   = state;

endmodule

// File: tb/tb_rcservo_frame_scheduler.sv
// Directed bench for rcservo_frame_scheduler with a 2-channel, 200-cycle frame.
module tb_rcservo_frame_scheduler;
  import rcservo_frame_scheduler_pkg::*;

  localparam int CH = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [32*CH-1:0]  cmd;
  logic [32*CH-1:0]  fb;
  logic [CH-1:0]     pwm;
  logic              frame_start;
  logic              busy;
  logic [2:0]        dbg_state;

  int checks = 0;
  int errors = 0;

  int run [CH];
  int last_w [CH];
  int rise_at [CH];
  int npulses [CH];
  int fcnt = 0;

  int exp_fb0 [8] = '{3, 6, 9, 12, 15, 18, 20, 20};
  int exp_fb1 [8] = '{-5, -10, -15, -20, -20, -20, -20, -20};

  rcservo_frame_scheduler #(
    .CHANNELS     (CH),
    .FRAME_LEN    (200),
    .SLOT_LEN     (80),
    .SERVO_CENTER (30),
    .SERVO_MINMAX (20),
    .VEL_SHIFT    (0),
    .MAX_SLEW     (5)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .jointFreqCmd  (cmd),
    .jointFeedback (fb),
    .PWM           (pwm),
    .frame_start   (frame_start),
    .busy          (busy),
    .dbg_state     (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [63:0] fbk(input int k);
    logic signed [31:0] v;
    v = fb[32*k +: 32];
    return 64'(v);
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fs(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 1000);
    if (!frame_start) chk("frame_start_timeout", 0, 1);
  endtask

  // Pulse monitor: measures widths and rise positions, and checks exclusivity.
  always @(negedge clk) begin
    if (reset) begin
      for (int k = 0; k < CH; k++) run[k] = 0;
    end else begin
      if (frame_start) fcnt = 0;
      else             fcnt++;
      for (int k = 0; k < CH; k++) begin
        if (pwm[k]) begin
          if (run[k] == 0) rise_at[k] = fcnt;
          run[k]++;
        end else if (run[k] > 0) begin
          last_w[k] = run[k];
          npulses[k]++;
          run[k] = 0;
        end
      end
      if ($countones(pwm) > 1) chk("pwm_onehot", 64'($countones(pwm)), 1);
    end
  end

  initial begin
    int n;
    int np1;
    for (int k = 0; k < CH; k++) begin
      run[k] = 0; last_w[k] = 0; rise_at[k] = -1; npulses[k] = 0;
    end
    reset = 1'b1;
    enable = 1'b0;
    cmd = '0;
    step(3);
    chk("reset_pwm", 64'(pwm), 0);
    chk("reset_busy", 64'(busy), 0);
    chk("reset_frame_start", 64'(frame_start), 0);
    chk("reset_fb0", fbk(0), 0);
    chk("reset_fb1", fbk(1), 0);
    chk("reset_state", 64'(dbg_state), 64'(ST_IDLE));
    reset = 1'b0;
    step(2);
    chk("idle_busy", 64'(busy), 0);

    // Frame timing with zero commands.
    enable = 1'b1;
    step(1);
    chk("first_frame_start", 64'(frame_start), 1);
    chk("first_busy", 64'(busy), 1);
    wait_fs(n);
    chk("frame_period", 64'(n), 200);
    chk("w0_center", 64'(last_w[0]), 30);
    chk("rise0_at", 64'(rise_at[0]), 2);
    chk("w1_center", 64'(last_w[1]), 30);
    chk("rise1_at", 64'(rise_at[1]), 82);

    // Positive ramp to saturation on ch0, slew-clamped descent on ch1.
    cmd[31:0]  = 32'sd3;
    cmd[63:32] = -32'sd100;
    for (int i = 0; i < 8; i++) begin
      step(120);
      chk($sformatf("ramp_fb0_%0d", i), fbk(0), 64'(exp_fb0[i]));
      chk($sformatf("ramp_w0_%0d", i), 64'(last_w[0]), 64'(30 + exp_fb0[i]));
      chk($sformatf("ramp_fb1_%0d", i), fbk(1), 64'(exp_fb1[i]));
      chk($sformatf("ramp_w1_%0d", i), 64'(last_w[1]), 64'(30 + exp_fb1[i]));
      wait_fs(n);
    end

    // Command change mid-pulse does not alter the running width.
    step(10);
    chk("mid_pulse_pwm", 64'(pwm), 1);
    cmd[31:0] = -32'sd5;
    wait_fs(n);
    chk("mid_change_w0", 64'(last_w[0]), 50);
    chk("mid_change_fb0_held", fbk(0), 20);
    step(60);
    chk("next_update_fb0", fbk(0), 15);
    chk("next_update_w0", 64'(last_w[0]), 45);
    wait_fs(n);

    // Disable during ch0 pulse: pulse completes, ch1 slot skipped.
    cmd = '0;
    np1 = npulses[1];
    step(11);
    chk("dis_pulse_active", 64'(pwm), 1);
    enable = 1'b0;
    step(60);
    chk("dis_w0_full", 64'(last_w[0]), 45);
    chk("dis_busy", 64'(busy), 0);
    chk("dis_pwm", 64'(pwm), 0);
    step(100);
    chk("dis_no_pwm1", 64'(npulses[1]), 64'(np1));
    chk("dis_fb0_held", fbk(0), 15);
    chk("dis_fb1_held", fbk(1), -20);
    chk("dis_state", 64'(dbg_state), 64'(ST_IDLE));

    // Re-enable restarts a frame immediately with positions retained.
    enable = 1'b1;
    step(1);
    chk("reen_frame_start", 64'(frame_start), 1);
    chk("reen_fb0", fbk(0), 15);

    // Reset in the middle of the ch1 pulse.
    step(90);
    chk("pre_reset_pwm1", 64'(pwm), 2);
    reset = 1'b1;
    step(1);
    chk("mid_reset_pwm", 64'(pwm), 0);
    chk("mid_reset_fb0", fbk(0), 0);
    chk("mid_reset_fb1", fbk(1), 0);
    chk("mid_reset_busy", 64'(busy), 0);
    chk("mid_reset_fs", 64'(frame_start), 0);
    reset = 1'b0;
    enable = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
